serial_bit_source: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the `fsm` sequence detector and drives its single-bit `xin` input. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `sout`. A one-word pending buffer lets consecutive words stream with no idle gap. This replaces hand-written per-cycle `xin` stimulus with a reusable, synthesizable source.

---
 rtl/serial_bit_source.sv | 145 ++++++++++++++
 tb/tb_serial_bit_source.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_source.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_source
// Description : Parallel-to-serial source with valid/ready input and a
//               one-word pending buffer for gap-free streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_source #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state, w_state;
    logic [WIDTH-1:0]   r_sr, w_sr;
    logic [WIDTH-1:0]   r_pb, w_pb;
    logic [c_CNT_W-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic               r_pb_full, w_pb_full;
    logic               r_sout, w_sout;
    logic               r_sout_valid, w_sout_valid;
    logic               r_word_done, w_word_done;
    logic               w_accept;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_word;

    // The shift register always holds the not-yet-emitted bits with the next
    // one at the output end, so a load consumes the first bit immediately.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign din_ready  = !r_pb_full && !flush;
    assign w_accept   = din_valid && din_ready;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign word_done  = r_word_done;
    assign busy       = (r_state == S_SHIFT) || r_pb_full;

    always_comb begin
        w_state      = r_state;
        w_sr         = r_sr;
        w_pb         = r_pb;
        w_cnt        = r_cnt;
        w_pb_full    = r_pb_full;
        w_sout       = r_sout;
        w_sout_valid = r_sout_valid;
        w_word_done  = r_word_done;
        w_load       = 1'b0;
        w_load_word  = din;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt != c_LAST) begin
                    w_sout      = first_bit(r_sr);
                    w_sr        = advance(r_sr);
                    w_cnt       = w_cnt_inc;
                    w_word_done = (w_cnt_inc == c_LAST);
                    if (w_accept) begin
                        w_pb      = din;
                        w_pb_full = 1'b1;
                    end
                end else begin
                    w_word_done = 1'b0;
                    if (r_pb_full) begin
                        w_load      = 1'b1;
                        w_load_word = r_pb;
                        w_pb_full   = 1'b0;
                    end else if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_state      = S_IDLE;
                        w_sout       = IDLE_LEVEL;
                        w_sout_valid = 1'b0;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_sr         = advance(w_load_word);
            w_sout       = first_bit(w_load_word);
            w_sout_valid = 1'b1;
            w_cnt        = '0;
            w_state      = S_SHIFT;
            w_word_done  = 1'b0;
        end
    end

    // Flush aborts exactly like reset, discarding in-flight and pending words.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_pb         <= '0;
            r_cnt        <= '0;
            r_pb_full    <= 1'b0;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_word_done  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_sr         <= w_sr;
            r_pb         <= w_pb;
            r_cnt        <= w_cnt;
            r_pb_full    <= w_pb_full;
            r_sout       <= w_sout;
            r_sout_valid <= w_sout_valid;
            r_word_done  <= w_word_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_source.sv
`default_nettype none
// Bench for serial_bit_source: an 8-bit MSB-first instance and a 4-bit
// LSB-first instance with idle level 1, checked against a bit scoreboard.
module tb_serial_bit_source;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       dv8, dv4;
    logic [7:0] din8, seq8;
    logic [3:0] din4, seq4;
    logic       rdy8, sout8, sv8, wd8, busy8;
    logic       rdy4, sout4, sv4, wd4, busy4;
    logic       mon_en;

    int checks = 0;
    int errors = 0;

    // Each entry is {expected serial bit, last-bit-of-word flag}.
    logic [1:0] q8[$];
    logic [1:0] q4[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq;
        int         gap;
    } vec8_t;

    typedef struct {
        logic [3:0] din;
        logic [3:0] seq;
        int         gap;
    } vec4_t;

    vec8_t tab8[7];
    vec4_t tab4[4];

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .din_valid(dv8), .din(din8), .din_ready(rdy8),
        .sout(sout8), .sout_valid(sv8), .word_done(wd8), .busy(busy8)
    );

    serial_bit_source #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .din_valid(dv4), .din(din4), .din_ready(rdy4),
        .sout(sout4), .sout_valid(sv4), .word_done(wd4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sout, sout_valid, word_done, busy, din_ready} from queue state.
    function automatic logic [4:0] exp_of(input int sz, input logic [1:0] h,
                                          input logic idle, input logic fl,
                                          input int w);
        if (sz > 0)
            return {h[1], 1'b1, h[0], 1'b1, (!fl && sz <= w)};
        return {idle, 1'b0, 1'b0, 1'b0, !fl};
    endfunction

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q8.delete();
            q4.delete();
        end else begin
            if (dv8 && rdy8)
                for (int i = 7; i >= 0; i--) q8.push_back({seq8[i], i == 0});
            if (dv4 && rdy4)
                for (int i = 3; i >= 0; i--) q4.push_back({seq4[i], i == 0});
        end
    end

    always @(negedge clk) begin : monitor
        logic [4:0] e;
        logic [4:0] g;
        if (mon_en) begin
            e = exp_of(q8.size(), (q8.size() > 0) ? q8[0] : 2'b00, 1'b0, flush, 8);
            g = {sout8, sv8, wd8, busy8, rdy8};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mon8 at %0t: got %b required %b (sout,valid,done,busy,ready)",
                         $time, g, e);
            end
            if (q8.size() > 0) void'(q8.pop_front());

            e = exp_of(q4.size(), (q4.size() > 0) ? q4[0] : 2'b00, 1'b1, flush, 4);
            g = {sout4, sv4, wd4, busy4, rdy4};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mon4 at %0t: got %b required %b (sout,valid,done,busy,ready)",
                         $time, g, e);
            end
            if (q4.size() > 0) void'(q4.pop_front());
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic [7:0] s, input int gap);
        bit acc = 1'b0;
        din8 = d; seq8 = s; dv8 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            if (rdy8) begin acc = 1'b1; break; end
        end
        chk("accept8_timeout", {7'd0, acc}, 8'd1);
        #1 dv8 = 1'b0; din8 = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send4(input logic [3:0] d, input logic [3:0] s, input int gap);
        bit acc = 1'b0;
        din4 = d; seq4 = s; dv4 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            if (rdy4) begin acc = 1'b1; break; end
        end
        chk("accept4_timeout", {7'd0, acc}, 8'd1);
        #1 dv4 = 1'b0; din4 = 4'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [7:0] v;

        // seq holds the bits in emission order, first bit at the MSB.
        tab8[0] = '{8'hAC, 8'hAC, 12};
        tab8[1] = '{8'hA5, 8'hA5, 0};
        tab8[2] = '{8'h3C, 8'h3C, 16};
        tab8[3] = '{8'hFF, 8'hFF, 7};   // next word lands exactly on the last-bit edge
        tab8[4] = '{8'h00, 8'h00, 3};
        tab8[5] = '{8'h5A, 8'h5A, 0};
        tab8[6] = '{8'hC3, 8'hC3, 20};
        tab4[0] = '{4'b0001, 4'b1000, 6};
        tab4[1] = '{4'b1011, 4'b1101, 0};
        tab4[2] = '{4'b0110, 4'b0110, 3};
        tab4[3] = '{4'b1110, 4'b0111, 8};

        rst_n = 1'b0; flush = 1'b0; mon_en = 1'b0;
        dv8 = 1'b0; dv4 = 1'b0; din8 = '0; din4 = '0; seq8 = '0; seq4 = '0;
        @(posedge clk); #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_sout8", sout8, 0);
        chk("rst_sout4", sout4, 1);
        chk("rst_valid8", sv8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_ready8", rdy8, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word 8'hAC, then return to idle.
        v = 8'hAC;
        din8 = v; seq8 = v; dv8 = 1'b1;
        @(posedge clk); #1 dv8 = 1'b0; din8 = 8'h55;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("single_bit", sout8, v[8-k]);
            chk("single_done", wd8, (k == 8));
            chk("single_busy", busy8, 1);
        end
        @(negedge clk);
        chk("single_idle_busy", busy8, 0);
        chk("single_idle_sout", sout8, 0);
        chk("single_idle_valid", sv8, 0);
        @(posedge clk); #1;

        // Back-to-back: second word goes to the pending buffer.
        din8 = 8'hA5; seq8 = 8'hA5; dv8 = 1'b1;
        @(posedge clk); #1 din8 = 8'h3C; seq8 = 8'h3C;
        @(posedge clk); #1 dv8 = 1'b0; din8 = 8'h99;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            chk("b2b_ready_low", rdy8, 0);
        end
        @(negedge clk);
        chk("b2b_ready_back", rdy8, 1);
        chk("b2b_busy", busy8, 1);
        repeat (12) @(posedge clk);
        #1;

        // Flush and then reset on the third bit of 8'hF0 with a word pending.
        for (int m = 0; m < 2; m++) begin
            din8 = 8'hF0; seq8 = 8'hF0; dv8 = 1'b1;
            @(posedge clk); #1 din8 = 8'h0F; seq8 = 8'h0F;
            @(posedge clk); #1 dv8 = 1'b0;
            @(posedge clk); #1;
            if (m == 0) flush = 1'b1; else rst_n = 1'b0;
            @(negedge clk);
            chk("abort_bit3", sout8, 1);
            chk("abort_cycle_ready", rdy8, 0);
            @(posedge clk); #1 flush = 1'b0; rst_n = 1'b1;
            @(negedge clk);
            chk("abort_sout", sout8, 0);
            chk("abort_valid", sv8, 0);
            chk("abort_busy", busy8, 0);
            chk("abort_ready", rdy8, 1);
            @(posedge clk); #1;
        end

        foreach (tab8[i]) send8(tab8[i].din, tab8[i].seq, tab8[i].gap);
        repeat (5) @(posedge clk);
        #1;
        foreach (tab4[i]) send4(tab4[i].din, tab4[i].seq, tab4[i].gap);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain8", 8'(q8.size()), 0);
        chk("drain4", 8'(q4.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
